debug_rx_frame: RTL and testbench

- Upstream neighbour of the OCD reply path. Consumes the UART receiver byte stream and hunts for the two-byte command sync.
- Collects the command byte and payload, then checks a CRC16-CCITT trailer.
- Hands validated frames to the command decoder as a one-cycle strobe with the command and payload registered.
- Bad-CRC frames and frames received while downstream is busy are dropped and flagged.

---
 rtl/debug_rx_frame_pkg.sv | 33 +++
 rtl/debug_rx_frame_if.sv | 39 +++
 rtl/debug_rx_frame_crc16.sv | 38 +++
 rtl/debug_rx_frame.sv | 189 ++++++++++++++++++
 tb/tb_debug_rx_frame.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/debug_rx_frame_pkg.sv
// -----------------------------------------------------------------------------
// debug_rx_frame_pkg
// Shared constants for the debug command receive path: data width, command
// sync bytes, CRC trailer length, default body length, and the byte-wise
// CRC16-CCITT update used by the receiver's CRC engine.
// -----------------------------------------------------------------------------
package debug_rx_frame_pkg;

  localparam int          DEBUG_DATA_WIDTH = 8;
  localparam logic [7:0]  DEBUG_CMD_SYNC0  = 8'h5A;
  localparam logic [7:0]  DEBUG_CMD_SYNC1  = 8'hA5;
  localparam int          DEBUG_CRC_LEN    = 2;
  localparam int          DEBUG_BODY_BYTES = 8;

  localparam int          DEBUG_CRC_W      = DEBUG_CRC_LEN * DEBUG_DATA_WIDTH;
  localparam logic [15:0] DEBUG_CRC_POLY   = 16'h1021;
  localparam logic [15:0] DEBUG_CRC_INIT   = 16'hFFFF;

  typedef logic [DEBUG_CRC_W-1:0] crc16_t;

  // One byte of CCITT CRC, MSB-first, unreflected.
  function automatic crc16_t crc16_ccitt_byte(input crc16_t crc_in,
                                              input logic [7:0] data);
    crc16_t c;
    c = crc_in ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (c[15]) c = {c[14:0], 1'b0} ^ DEBUG_CRC_POLY;
      else       c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/debug_rx_frame_if.sv
// -----------------------------------------------------------------------------
// debug_rx_frame_if
// Bundles the receiver's byte input, downstream-ready input and the frame
// hand-off outputs.
//   master : UART side / command decoder side (drives bytes and rx_enable)
//   slave  : debug_rx_frame (drives frame outputs and status pulses)
// Signals: uart_rx_valid, uart_rx_data[7:0], rx_enable, frame_valid,
//          frame_cmd[7:0], frame_payload[(BODY_BYTES-1)*8-1:0], crc_error,
//          overrun, rx_busy.
// -----------------------------------------------------------------------------
interface debug_rx_frame_if
  import debug_rx_frame_pkg::*;
#(
  parameter int BODY_BYTES = DEBUG_BODY_BYTES
);

  localparam int PAY_W = (BODY_BYTES - 1) * DEBUG_DATA_WIDTH;

  logic                        uart_rx_valid;
  logic [DEBUG_DATA_WIDTH-1:0] uart_rx_data;
  logic                        rx_enable;
  logic                        frame_valid;
  logic [DEBUG_DATA_WIDTH-1:0] frame_cmd;
  logic [PAY_W-1:0]            frame_payload;
  logic                        crc_error;
  logic                        overrun;
  logic                        rx_busy;

  modport master (
    output uart_rx_valid, uart_rx_data, rx_enable,
    input  frame_valid, frame_cmd, frame_payload, crc_error, overrun, rx_busy
  );

  modport slave (
    input  uart_rx_valid, uart_rx_data, rx_enable,
    output frame_valid, frame_cmd, frame_payload, crc_error, overrun, rx_busy
  );

endinterface

// File: rtl/debug_rx_frame_crc16.sv
// -----------------------------------------------------------------------------
// crc16_CCITT
// Byte-serial CRC16-CCITT engine (poly 0x1021, init 0xFFFF, no reflection,
// no final XOR).
// Ports:
//   clk, rst_n  : clock, async active-low reset (register returns to init)
//   sync_reset  : reload init value this cycle (has priority over crc_en)
//   crc_en      : fold data_in into the running CRC
//   data_in     : byte to fold
//   crc_out     : registered running CRC
// -----------------------------------------------------------------------------
module crc16_CCITT
  import debug_rx_frame_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sync_reset,
  input  logic                        crc_en,
  input  logic [DEBUG_DATA_WIDTH-1:0] data_in,
  output crc16_t                      crc_out
);

  crc16_t crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (sync_reset)  crc_d = DEBUG_CRC_INIT;
    else if (crc_en) crc_d = crc16_ccitt_byte(crc_q, data_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= DEBUG_CRC_INIT;
    else        crc_q <= crc_d;
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/debug_rx_frame.sv
// -----------------------------------------------------------------------------
// debug_rx_frame
// Hunts the UART byte stream for the two-byte command sync, collects the
// command byte and payload, checks the CRC16-CCITT trailer (high byte first,
// covering the body only) and hands good frames to the command decoder as a
// one-cycle frame_valid with command/payload registered.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   rx_if.slave  : byte input (uart_rx_valid/uart_rx_data), rx_enable,
//                  frame_valid/frame_cmd/frame_payload, crc_error, overrun,
//                  rx_busy
// Build option:
//   DEBUG_RX_TIMEOUT_EN : enables an inter-byte idle timeout of
//                         TIMEOUT_CYCLES that abandons a partial frame.
//
// state         | meaning
// --------------+---------------------------------------------------------
// S_HUNT_SYNC0  | idle, CRC held at init, waiting for SYNC0
// S_HUNT_SYNC1  | SYNC0 seen, waiting for SYNC1
// S_BODY        | collecting command + payload bytes into CRC and shifter
// S_CRC_HI      | waiting for CRC trailer high byte
// S_CRC_LO      | waiting for CRC trailer low byte, then judge the frame
// -----------------------------------------------------------------------------
module debug_rx_frame
  import debug_rx_frame_pkg::*;
#(
  parameter logic [7:0] SYNC0          = DEBUG_CMD_SYNC0,
  parameter logic [7:0] SYNC1          = DEBUG_CMD_SYNC1,
  parameter int         BODY_BYTES     = DEBUG_BODY_BYTES,
  parameter int         TIMEOUT_CYCLES = 100000
)(
  input  logic       clk,
  input  logic       reset_n,
  debug_rx_frame_if.slave rx_if
);

  localparam int BODY_W = BODY_BYTES * DEBUG_DATA_WIDTH;
  localparam int PAY_W  = (BODY_BYTES - 1) * DEBUG_DATA_WIDTH;

  localparam logic [4:0] S_HUNT_SYNC0 = 5'b00001;
  localparam logic [4:0] S_HUNT_SYNC1 = 5'b00010;
  localparam logic [4:0] S_BODY       = 5'b00100;
  localparam logic [4:0] S_CRC_HI     = 5'b01000;
  localparam logic [4:0] S_CRC_LO     = 5'b10000;

  localparam logic [4:0] CNT_LAST = 5'(BODY_BYTES - 1);

  logic [4:0]                  state_q, state_d;
  logic [4:0]                  cnt_q, cnt_d;
  logic [BODY_W-1:0]           shreg_q, shreg_d;
  logic [7:0]                  crc_hi_q, crc_hi_d;
  logic                        frame_valid_q, frame_valid_d;
  logic                        crc_error_q, crc_error_d;
  logic                        overrun_q, overrun_d;
  logic [7:0]                  frame_cmd_q, frame_cmd_d;
  logic [PAY_W-1:0]            frame_payload_q, frame_payload_d;

  logic                        timeout_hit;
  logic                        byte_v;
  logic                        crc_en;
  crc16_t                      crc_out;

  // A strobe landing on the timeout cycle is discarded along with the frame.
  assign byte_v = rx_if.uart_rx_valid & ~timeout_hit;
  assign crc_en = byte_v & (state_q == S_BODY);

`ifdef DEBUG_RX_TIMEOUT_EN
  logic [16:0] idle_q, idle_d;

  always_comb begin
    idle_d = idle_q;
    if (rx_if.uart_rx_valid)   idle_d = '0;
    else if (idle_q != '1)     idle_d = idle_q + 17'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) idle_q <= '0;
    else          idle_q <= idle_d;
  end

  assign timeout_hit = (state_q != S_HUNT_SYNC0) &&
                       (idle_q >= 17'(TIMEOUT_CYCLES));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  crc16_CCITT u_crc (
    .clk        (clk),
    .rst_n      (reset_n),
    .sync_reset (state_q == S_HUNT_SYNC0),
    .crc_en     (crc_en),
    .data_in    (rx_if.uart_rx_data),
    .crc_out    (crc_out)
  );

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    shreg_d         = shreg_q;
    crc_hi_d        = crc_hi_q;
    frame_cmd_d     = frame_cmd_q;
    frame_payload_d = frame_payload_q;
    frame_valid_d   = 1'b0;
    crc_error_d     = 1'b0;
    overrun_d       = 1'b0;

    case (state_q)
      S_HUNT_SYNC0: begin
        if (byte_v && rx_if.uart_rx_data == SYNC0) state_d = S_HUNT_SYNC1;
      end
      S_HUNT_SYNC1: begin
        if (byte_v) begin
          if (rx_if.uart_rx_data == SYNC1) begin
            cnt_d   = '0;
            state_d = S_BODY;
          end else if (rx_if.uart_rx_data != SYNC0) begin
            state_d = S_HUNT_SYNC0;
          end
        end
      end
      S_BODY: begin
        if (byte_v) begin
          shreg_d = {shreg_q[BODY_W-DEBUG_DATA_WIDTH-1:0], rx_if.uart_rx_data};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == CNT_LAST) state_d = S_CRC_HI;
        end
      end
      S_CRC_HI: begin
        if (byte_v) begin
          crc_hi_d = rx_if.uart_rx_data;
          state_d  = S_CRC_LO;
        end
      end
      S_CRC_LO: begin
        if (byte_v) begin
          state_d = S_HUNT_SYNC0;
          if ({crc_hi_q, rx_if.uart_rx_data} == crc_out) begin
            if (rx_if.rx_enable) begin
              frame_valid_d   = 1'b1;
              frame_cmd_d     = shreg_q[BODY_W-1 -: DEBUG_DATA_WIDTH];
              frame_payload_d = shreg_q[PAY_W-1:0];
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            crc_error_d = 1'b1;
          end
        end
      end
      default: state_d = S_HUNT_SYNC0;
    endcase

    if (timeout_hit) state_d = S_HUNT_SYNC0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_HUNT_SYNC0;
      cnt_q           <= '0;
      shreg_q         <= '0;
      crc_hi_q        <= '0;
      frame_valid_q   <= 1'b0;
      crc_error_q     <= 1'b0;
      overrun_q       <= 1'b0;
      frame_cmd_q     <= '0;
      frame_payload_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      shreg_q         <= shreg_d;
      crc_hi_q        <= crc_hi_d;
      frame_valid_q   <= frame_valid_d;
      crc_error_q     <= crc_error_d;
      overrun_q       <= overrun_d;
      frame_cmd_q     <= frame_cmd_d;
      frame_payload_q <= frame_payload_d;
    end
  end

  assign rx_if.frame_valid   = frame_valid_q;
  assign rx_if.crc_error     = crc_error_q;
  assign rx_if.overrun       = overrun_q;
  assign rx_if.frame_cmd     = frame_cmd_q;
  assign rx_if.frame_payload = frame_payload_q;
  assign rx_if.rx_busy       = (state_q != S_HUNT_SYNC0);

endmodule

// File: tb/tb_debug_rx_frame.sv
// -----------------------------------------------------------------------------
// tb_debug_rx_frame
// Directed frames for debug_rx_frame with BODY_BYTES=9 and TIMEOUT_CYCLES=50.
// Stimulus pushes the expected event (kind, held cmd/payload, cycle) into a
// queue; a negedge monitor pops and compares whenever a pulse appears.
// -----------------------------------------------------------------------------
module tb_debug_rx_frame;
  import debug_rx_frame_pkg::*;

  localparam int BB    = 9;
  localparam int PAY_W = (BB - 1) * 8;

  localparam logic [1:0] K_FRAME = 2'd0;
  localparam logic [1:0] K_CRC   = 2'd1;
  localparam logic [1:0] K_OVR   = 2'd2;

  typedef logic [7:0] byte_arr_t[$];
  typedef struct {
    logic [1:0]       kind;
    logic [7:0]       cmd;
    logic [PAY_W-1:0] pay;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  debug_rx_frame_if #(.BODY_BYTES(BB)) rx_if ();

  debug_rx_frame #(
    .SYNC0          (8'h5A),
    .SYNC1          (8'hA5),
    .BODY_BYTES     (BB),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rx_if   (rx_if)
  );

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  localparam logic [7:0]       G_CMD = 8'h31;
  localparam logic [PAY_W-1:0] G_PAY = 64'h3233343536373839;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset_n) begin
      int   pulses;
      logic [1:0] got_kind;
      exp_t e;
      pulses = int'(rx_if.frame_valid) + int'(rx_if.crc_error) + int'(rx_if.overrun);
      if (pulses != 0) begin
        n_cmp++;
        got_kind = rx_if.frame_valid ? K_FRAME : (rx_if.crc_error ? K_CRC : K_OVR);
        if (pulses > 1) begin
          n_bad++;
          $display("FAIL pulse_exclusive: got %0d simultaneous pulses, want 1 at cycle %0d", pulses, cyc);
        end else if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: got kind=%0d at cycle %0d, want no event", got_kind, cyc);
        end else begin
          e = exp_q.pop_front();
          if (got_kind !== e.kind || rx_if.frame_cmd !== e.cmd ||
              rx_if.frame_payload !== e.pay || cyc != e.cyc) begin
            n_bad++;
            $display("FAIL event: got kind=%0d cmd=%h pay=%h cyc=%0d, want kind=%0d cmd=%h pay=%h cyc=%0d",
                     got_kind, rx_if.frame_cmd, rx_if.frame_payload, cyc,
                     e.kind, e.cmd, e.pay, e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Drives bytes back-to-back; rx_enable follows en_last on the final byte.
  task automatic send(input byte_arr_t b, input logic en_last, input bit expect_evt,
                      input logic [1:0] kind, input logic [7:0] cmd,
                      input logic [PAY_W-1:0] pay);
    for (int i = 0; i < b.size(); i++) begin
      @(negedge clk);
      rx_if.uart_rx_valid = 1'b1;
      rx_if.uart_rx_data  = b[i];
      rx_if.rx_enable     = (i == b.size() - 1) ? en_last : 1'b1;
      if (i == b.size() - 1 && expect_evt)
        exp_q.push_back('{kind: kind, cmd: cmd, pay: pay, cyc: cyc + 1});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_if.uart_rx_valid = 1'b0;
      rx_if.uart_rx_data  = 8'h00;
      rx_if.rx_enable     = 1'b1;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_frame_valid"},   64'(rx_if.frame_valid),   64'd0);
    chk({tag, "_crc_error"},     64'(rx_if.crc_error),     64'd0);
    chk({tag, "_overrun"},       64'(rx_if.overrun),       64'd0);
    chk({tag, "_frame_cmd"},     64'(rx_if.frame_cmd),     64'd0);
    chk({tag, "_frame_payload"}, 64'(rx_if.frame_payload), 64'd0);
    chk({tag, "_rx_busy"},       64'(rx_if.rx_busy),       64'd0);
  endtask

  byte_arr_t golden, bad, prefix;

  initial begin
    golden = '{8'h5A, 8'hA5, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
               8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
    bad    = golden;
    bad[12] = 8'hB0;
    prefix = '{8'h5A, 8'h5A, 8'h11, 8'h5A};

    rx_if.uart_rx_valid = 1'b0;
    rx_if.uart_rx_data  = 8'h00;
    rx_if.rx_enable     = 1'b1;

    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;
    idle(2);

    // Bad CRC before any good frame: outputs stay at reset values
    send(bad, 1'b1, 1'b1, K_CRC, 8'h00, '0);
    idle(3);

    send(golden, 1'b1, 1'b1, K_FRAME, G_CMD, G_PAY);
    idle(3);

    // Bad CRC after a good frame: golden values held
    send(bad, 1'b1, 1'b1, K_CRC, G_CMD, G_PAY);
    idle(3);

    send({prefix, golden}, 1'b1, 1'b1, K_FRAME, G_CMD, G_PAY);
    idle(3);

    send(golden, 1'b0, 1'b1, K_OVR, G_CMD, G_PAY);
    idle(3);
    send(golden, 1'b1, 1'b1, K_FRAME, G_CMD, G_PAY);

    // Back-to-back: second frame's sync arrives while frame_valid is high
    send(golden, 1'b1, 1'b1, K_FRAME, G_CMD, G_PAY);
    idle(3);

    // Reset mid-body, then a clean frame
    send(golden[0:7], 1'b1, 1'b0, K_FRAME, '0, '0);
    idle(1);
    chk("midbody_rx_busy", 64'(rx_if.rx_busy), 64'd1);
    reset_n = 1'b0;
    #1;
    chk_zero("midreset");
    idle(2);
    reset_n = 1'b1;
    idle(2);
    send(golden, 1'b1, 1'b1, K_FRAME, G_CMD, G_PAY);
    idle(3);

    // Mid-body stall of 60 idle cycles
    send(golden[0:4], 1'b1, 1'b0, K_FRAME, '0, '0);
    idle(60);
`ifdef DEBUG_RX_TIMEOUT_EN
    chk("stall_rx_busy", 64'(rx_if.rx_busy), 64'd0);
    send(golden[5:12], 1'b1, 1'b0, K_FRAME, '0, '0);
`else
    chk("stall_rx_busy", 64'(rx_if.rx_busy), 64'd1);
    send(golden[5:12], 1'b1, 1'b1, K_FRAME, G_CMD, G_PAY);
`endif
    idle(3);
    send(golden, 1'b1, 1'b1, K_FRAME, G_CMD, G_PAY);
    idle(5);

    chk("pending_events", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
